// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel status-LED controller with off / on / blink / activity modes.
// Define LED_CTRL_PWM_EN to build the 2-bit brightness PWM gate on every channel.
module led_ctrl #(
    parameter int NUM_LEDS    = 3,
    parameter int TICK_DIV    = 600000,
    parameter int ACT_STRETCH = 5,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WR_EN,
    input  logic [3:0]          WR_ADDR,
    input  logic [7:0]          WR_DATA,
    input  logic [NUM_LEDS-1:0] ACT,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ACT   = 2'd3
    } mode_e;

    localparam int               PRE_W        = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       STRETCH_LOAD = 8'(ACT_STRETCH);

    logic [PRE_W-1:0]         pre_q, pre_d;
    logic [NUM_LEDS-1:0][7:0] cfg_q, cfg_d;
    logic [NUM_LEDS-1:0][3:0] blk_cnt_q, blk_cnt_d;
    logic [NUM_LEDS-1:0]      phase_q, phase_d;
    logic [NUM_LEDS-1:0][7:0] str_q, str_d;
    logic [NUM_LEDS-1:0]      lit;
    logic [NUM_LEDS-1:0]      led_d;

    assign TICK = (pre_q == PRE_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pre_d     = TICK ? '0 : pre_q + PRE_W'(1);
        cfg_d     = cfg_q;
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        str_d     = str_q;
        lit       = '0;

        for (int i = 0; i < NUM_LEDS; i++) begin
            // A write restarts the blink so the new pattern always begins with a lit half-period.
            if (WR_EN && (WR_ADDR == 4'(i))) begin
                cfg_d[i]     = WR_DATA;
                blk_cnt_d[i] = '0;
                phase_d[i]   = 1'b1;
            end else if (TICK && (mode_e'(cfg_q[i][1:0]) == MODE_BLINK)) begin
                if (blk_cnt_q[i] == cfg_q[i][5:2]) begin
                    blk_cnt_d[i] = '0;
                    phase_d[i]   = ~phase_q[i];
                end else begin
                    blk_cnt_d[i] = blk_cnt_q[i] + 4'd1;
                end
            end

            if (ACT[i]) begin
                str_d[i] = STRETCH_LOAD;
            end else if (TICK && (str_q[i] != 8'd0)) begin
                str_d[i] = str_q[i] - 8'd1;
            end

            case (mode_e'(cfg_q[i][1:0]))
                MODE_OFF:   lit[i] = 1'b0;
                MODE_ON:    lit[i] = 1'b1;
                MODE_BLINK: lit[i] = phase_q[i];
                MODE_ACT:   lit[i] = (str_q[i] != 8'd0);
                default:    lit[i] = 1'b0;
            endcase
        end
    end

`ifdef LED_CTRL_PWM_EN
    logic [1:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 2'd1;

    always_ff @(posedge CLK) begin
        if (RST) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end

    // Duty is (B+1)/4: the channel is lit while the free-running counter is at or below B.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = (lit[i] & (pwm_q <= cfg_q[i][7:6])) ^ ACTIVE_LOW;
        end
    end
`else
    logic unused_bright;

    assign unused_bright = ^cfg_q;
    assign led_d         = lit ^ {NUM_LEDS{ACTIVE_LOW}};
`endif

    always_ff @(posedge CLK) begin
        // NOTE: the per-channel arrays are plain flops, so all of them are reset, not just the prescaler.
        if (RST) begin
            pre_q     <= '0;
            cfg_q     <= '0;
            blk_cnt_q <= '0;
            phase_q   <= '1;
            str_q     <= '0;
            LED       <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            pre_q     <= pre_d;
            cfg_q     <= cfg_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            str_q     <= str_d;
            LED       <= led_d;
        end
    end

endmodule
